// File: rtl/out_requant_pack.sv
// out_requant_pack
//   Takes the signed ACC_W-bit result stream of the post-accumulator op stage.
//   Each element is requantised with a rounding arithmetic right shift and
//   narrowed to ELEM_W bits. Elements are then packed LANES = BUS_W/ELEM_W to
//   a word, with a per-lane strobe, and handed to the write-back buffer.
//
//   Optional build macro OUT_REQUANT_SAT_EN: when it is defined, the narrowed
//   element is clamped to the signed ELEM_W range. When it is undefined, the
//   element keeps only its low ELEM_W bits.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_shift [SHIFT_W]   right-shift amount, held stable while busy
//   in_valid/in_ready     input element handshake
//   in_data   [ACC_W]     signed input element
//   in_last               last element of tile, flushes the partial word
//   out_valid/out_ready   packed word handshake
//   out_data  [BUS_W]     packed word, lane i = [i*ELEM_W +: ELEM_W]
//   out_strb  [LANES]     per-lane valid mask
//   out_last              word carries the tile's last element
//   busy                  partial word pending or output word held
module out_requant_pack #(
   parameter int ACC_W   = 32,
   parameter int ELEM_W  = 8,
   parameter int BUS_W   = 64,
   parameter int SHIFT_W = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [SHIFT_W-1:0]        cfg_shift,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [ACC_W-1:0]   in_data,
   input  logic                      in_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [BUS_W-1:0]          out_data,
   output logic [BUS_W/ELEM_W-1:0]   out_strb,
   output logic                      out_last,
   output logic                      busy
);

   localparam int LANES = BUS_W / ELEM_W;
   localparam int LC_W  = (LANES > 1) ? $clog2(LANES) : 1;

   logic [LC_W-1:0]         lane_cnt;
   logic [BUS_W-1:0]        asm_data;
   logic [BUS_W-1:0]        word_nxt;
   logic [LANES-1:0]        strb_nxt;
   logic [31:0]             sh;
   logic signed [ACC_W:0]   x_ext;
   logic signed [ACC_W:0]   rnd;
   logic signed [ACC_W:0]   sum;
   logic signed [ACC_W:0]   y;
   logic [ELEM_W-1:0]       elem;
   logic                    accept;
   logic                    complete;

   // The rounding add is done one bit wider than the input, so that adding
   // 2^(s-1) to the most positive input cannot wrap to a negative value.
   always_comb begin
      sh    = 32'(cfg_shift);
      x_ext = {in_data[ACC_W-1], in_data};
      rnd   = '0;
      sum   = x_ext;
      y     = x_ext;
      if (sh == 32'd0) begin
         y = x_ext;
      end else if (sh >= 32'(ACC_W)) begin
         y = in_data[ACC_W-1] ? '1 : '0;
      end else begin
         rnd = (ACC_W+1)'(1) << (sh - 32'd1);
         sum = x_ext + rnd;
         y   = sum >>> sh;
      end
   end

`ifdef OUT_REQUANT_SAT_EN
   localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2 ** (ELEM_W-1)) - 1);
   localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

   always_comb begin
      if (y > SAT_MAX)
         elem = SAT_MAX[ELEM_W-1:0];
      else if (y < SAT_MIN)
         elem = SAT_MIN[ELEM_W-1:0];
      else
         elem = y[ELEM_W-1:0];
   end
`else
   // Plain truncation. The discarded high bits feed a sink net only.
   logic unused_y_hi;
   assign elem        = y[ELEM_W-1:0];
   assign unused_y_hi = ^y[ACC_W:ELEM_W];
`endif

   // The assembly register is cleared whenever a word completes, so the
   // lanes above the current element are already zero.
   always_comb begin
      word_nxt = asm_data;
      word_nxt[lane_cnt*ELEM_W +: ELEM_W] = elem;
      for (int i = 0; i < LANES; i++)
         strb_nxt[i] = (LC_W'(i) <= lane_cnt);
   end

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign complete = (lane_cnt == LC_W'(LANES-1)) || in_last;
   assign busy     = (lane_cnt != '0) || out_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_cnt  <= '0;
         asm_data  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_strb  <= '0;
         out_last  <= 1'b0;
      end else if (accept && complete) begin
         // The output register is free here: either it is empty, or it is
         // being handed off in this same cycle.
         out_valid <= 1'b1;
         out_data  <= word_nxt;
         out_strb  <= strb_nxt;
         out_last  <= in_last;
         asm_data  <= '0;
         lane_cnt  <= '0;
      end else begin
         if (accept) begin
            asm_data <= word_nxt;
            lane_cnt <= lane_cnt + LC_W'(1);
         end
         if (out_valid && out_ready)
            out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_out_requant_pack.sv
module tb_out_requant_pack;

   logic               clk;
   logic               rst_n;
   logic [4:0]         cfg_shift;
   logic               in_valid;
   logic               in_ready;
   logic signed [31:0] in_data;
   logic               in_last;
   logic               out_valid;
   logic               out_ready;
   logic [63:0]        out_data;
   logic [7:0]         out_strb;
   logic               out_last;
   logic               busy;

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  s;
      logic        l;
   } exp_t;

   exp_t q[$];
   int   n_checks   = 0;
   int   n_fail     = 0;
   int   n_pushed   = 0;
   int   words_seen = 0;

   out_requant_pack dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_shift (cfg_shift),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_strb  (out_strb),
      .out_last  (out_last),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [63:0] d, input logic [7:0] s, input logic l);
      exp_t e;
      e.d = d;
      e.s = s;
      e.l = l;
      q.push_back(e);
      n_pushed++;
   endtask

   // Called at a negedge. Returns at the negedge after the element is taken.
   task automatic send(input logic signed [31:0] x, input logic last);
      int n;
      bit acc;
      n   = 0;
      acc = 1'b0;
      in_valid = 1'b1;
      in_data  = x;
      in_last  = last;
      while (!acc && n < 200) begin
         #1;
         acc = in_ready;
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      if (!acc) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: element %h not accepted, required acceptance within 200 cycles", x);
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || out_valid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (n >= 200) begin
         n_fail++;
         $display("FAIL drain_timeout: %0d words still expected, required 0", q.size());
      end
   endtask

   // Scoreboard monitor: samples 2 time units after each negedge.
   initial begin : monitor
      exp_t        e;
      bit          hold_vld;
      logic [63:0] hold_d;
      logic [7:0]  hold_s;
      logic        hold_l;
      hold_vld = 1'b0;
      hold_d   = '0;
      hold_s   = '0;
      hold_l   = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            hold_vld = 1'b0;
            continue;
         end
         if (hold_vld) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", out_data, hold_d);
            chk("hold_strb", 64'(out_strb), 64'(hold_s));
            chk("hold_last", 64'(out_last), 64'(hold_l));
         end
         if (out_valid && !out_ready)
            chk("in_ready_while_held", 64'(in_ready), 64'd0);
         if (out_valid && out_ready) begin
            words_seen++;
            if (q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_word: got %h strb %h, required no word", out_data, out_strb);
            end else begin
               e = q.pop_front();
               chk("word_data", out_data, e.d);
               chk("word_strb", 64'(out_strb), 64'(e.s));
               chk("word_last", 64'(out_last), 64'(e.l));
            end
         end
         hold_vld = out_valid && !out_ready;
         hold_d   = out_data;
         hold_s   = out_strb;
         hold_l   = out_last;
      end
   end

   initial begin : stim
      rst_n     = 1'b0;
      cfg_shift = '0;
      out_ready = 1'b1;
      idle();
      repeat (3) @(posedge clk);
      #2;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_out_strb", 64'(out_strb), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Full word: 1..8, last on 8th
      push(64'h0807060504030201, 8'hFF, 1'b1);
      for (int i = 1; i <= 8; i++) send(i, i == 8);
      idle();
      drain();

      // Partial word, then the next element must land in lane 0
      push(64'h0000000000070605, 8'h07, 1'b1);
      push(64'h0000000000000009, 8'h01, 1'b1);
      send(5, 1'b0);
      send(6, 1'b0);
      send(7, 1'b1);
      send(9, 1'b1);
      idle();
      drain();

      // Rounding shift=2: 23->6, -23->-6, 2->1, -2->0
      cfg_shift = 5'd2;
      push(64'h000000000001FA06, 8'h0F, 1'b1);
      send(23, 1'b0);
      send(-23, 1'b0);
      send(2, 1'b0);
      send(-2, 1'b1);
      idle();
      drain();

      // shift=31 extremes: the rounding add needs the extra bit
      cfg_shift = 5'd31;
      push(64'h000000000000FF01, 8'h07, 1'b1);
      send(32'sh7FFFFFFF, 1'b0);
      send(32'sh80000000, 1'b0);
      send(-1, 1'b1);
      idle();
      drain();

      // shift=1: 3->2, -3->-1, 1->1, -1->0
      cfg_shift = 5'd1;
      push(64'h000000000001FF02, 8'h0F, 1'b1);
      send(3, 1'b0);
      send(-3, 1'b0);
      send(1, 1'b0);
      send(-1, 1'b1);
      idle();
      drain();

      // Narrowing of out-of-range values
      cfg_shift = 5'd0;
`ifdef OUT_REQUANT_SAT_EN
      push(64'h000000000000807F, 8'h03, 1'b1);
`else
      push(64'h000000000000D42C, 8'h03, 1'b1);
`endif
      send(300, 1'b0);
      send(-300, 1'b1);
      idle();
      drain();

      // Backpressure: 16 elements, out_ready low for 10 cycles after first word
      push(64'h0807060504030201, 8'hFF, 1'b0);
      push(64'h100F0E0D0C0B0A09, 8'hFF, 1'b1);
      fork
         begin
            for (int i = 1; i <= 16; i++) send(i, i == 16);
            idle();
         end
         begin
            int n;
            n = 0;
            while (!out_valid && n < 200) begin
               @(negedge clk);
               n++;
            end
            out_ready = 1'b0;
            repeat (10) @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset in the middle of a word
      send(1, 1'b0);
      send(2, 1'b0);
      send(3, 1'b0);
      idle();
      #1;
      chk("busy_partial", 64'(busy), 64'd1);
      #2;
      rst_n = 1'b0;
      #2;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_out_data", out_data, 64'd0);
      chk("midrst_out_strb", 64'(out_strb), 64'd0);
      chk("midrst_out_last", 64'(out_last), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push(64'h1817161514131211, 8'hFF, 1'b1);
      for (int i = 0; i < 8; i++) send(32'h11 + i, i == 7);
      idle();
      drain();
      repeat (4) @(negedge clk);

      chk("words_total", 64'(words_seen), 64'(n_pushed));
      chk("queue_empty", 64'(q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
